comma_aligner: RTL
==================

Name: comma_aligner

Overview:
- Receiver physical-layer stage placed directly downstream of the 10-bit serial-to-parallel shifter.
- Watches the shifter's sliding 10-bit window every bit clock and finds K28.5 comma symbols.
- Establishes symbol-boundary lock, then emits one aligned 10-bit symbol per 10 clocks, with a strobe, to the 8b/10b decoder.

Parameters:
- LOCK_COMMAS, 2: consecutive boundary-aligned commas required to declare lock (range 1..15).
- UNLOCK_COMMAS, 4: consecutive misaligned commas, seen while locked, that force loss of lock (range 1..15).
- COMMA_N, 10'h0FA: K28.5 RD- pattern in window order, bit 9 = first received bit 'a'.
- COMMA_P, 10'h305: K28.5 RD+ pattern in window order.

Ports:
- clk  input  1: bit clock, same clock as the upstream shifter.
- rst_n  input  1: asynchronous active-low reset.
- parallel_in  input  10: sliding window from the shifter; bit 0 = newest bit, bit 9 = oldest bit.
- symbol_out  output  10: aligned symbol, same bit order as parallel_in.
- symbol_valid  output  1: one-cycle strobe; symbol_out is valid in this cycle.
- locked  output  1: high while in LOCKED state.
- comma_det  output  1: pulses together with symbol_valid when symbol_out is a comma.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. While rst_n=0, all outputs are 0, state is HUNT, and all counters are 0. Reset takes effect immediately, mid-operation included.
- Comma match: parallel_in equals COMMA_N or COMMA_P. Matching is combinational on the current window.
- Phase counter, mod 10:
  - Loaded so that the detection cycle t is a boundary.
  - Boundaries then occur at t+10k.
  - Increments every cycle in CONFIRM and LOCKED.
- HUNT:
  - Comma match sets boundary phase to the current cycle, sets comma count to 1, and moves to CONFIRM.
  - If LOCK_COMMAS=1, go directly to LOCKED instead.
  - No outputs are produced in HUNT.
- CONFIRM:
  - Comma at a boundary increments comma count. When count reaches LOCK_COMMAS, go to LOCKED.
  - Non-comma at a boundary is ignored; the state holds.
  - Comma at a non-boundary cycle realigns: new phase, count=1, stay in CONFIRM.
- LOCKED:
  - At every boundary, symbol_out <= parallel_in, symbol_valid=1, and comma_det=match, all registered, so outputs appear 1 cycle after the boundary cycle.
  - An aligned comma clears the misalign count.
  - A comma at a non-boundary cycle increments the misalign count. When it reaches UNLOCK_COMMAS, go to HUNT on the next edge; outputs are not realigned until a later relock.
- Lock-entry timing: the boundary that completes lock produces output. locked rises, and symbol_valid and comma_det pulse with that comma, all in the same cycle, one cycle after that boundary.
- Lock-exit timing: locked falls one cycle after the UNLOCK_COMMAS-th misaligned comma. No symbol_valid is produced after that point.
- Between strobes: symbol_out holds its last value, and symbol_valid and comma_det are 0.
- Strobe spacing: symbol_valid never asserts on two cycles closer than 10 apart.
- Latency: 1 clock from the boundary window to the registered output.

Test Plan:
- Reset: hold rst_n=0 with random parallel_in -> symbol_out=0, symbol_valid=0, locked=0, comma_det=0. Assert rst_n=0 asynchronously mid-LOCKED -> all outputs 0 immediately, with no clk edge needed.
- Acquisition: drive through the upstream shifter 7 random bits, then COM (RD-) followed by D-symbols, then COM again 10 symbols later. Required response:
  - locked=1 one cycle after the second COM window.
  - symbol_valid pulses with symbol_out=0x0FA and comma_det=1.
  - Further strobes every exactly 10 clocks with the data symbols in order.
- Realign in CONFIRM: first COM, then COM offset by 3 bits. Required response:
  - Count restarts at the new phase.
  - Lock occurs only after the next aligned COM (RD+ 0x305); no strobes before that.
- Loss of lock: in LOCKED, insert one extra bit into the stream, then send 4 COMs at the new phase. Required response:
  - locked drops one cycle after the 4th misaligned COM window.
  - Two further aligned COMs relock at the new phase.
- Hysteresis: in LOCKED, send 3 misaligned COMs, then 1 aligned COM, then 3 misaligned COMs -> locked stays 1 throughout, and strobes continue at the original phase.
- Non-comma rejection: a stream containing 0x0FA-like bit patterns that do not equal either comma value exactly (one bit flipped) -> never leaves HUNT, and all outputs stay 0.

Source files
------------

// File: rtl/comma_aligner.sv
// K28.5 comma aligner: hunts for commas in the shifter window, confirms the boundary, emits one symbol per 10 clocks.
// Latency 1 clock from boundary window to registered output; no backpressure (decoder must accept every strobe).
module comma_aligner #(
  parameter int          LOCK_COMMAS   = 2,
  parameter int          UNLOCK_COMMAS = 4,
  parameter logic [9:0]  COMMA_N       = 10'h0FA,
  parameter logic [9:0]  COMMA_P       = 10'h305
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] parallel_in,
  output logic [9:0] symbol_out,
  output logic       symbol_valid,
  output logic       locked,
  output logic       comma_det
);

  localparam logic [3:0] LOCK_N   = 4'(LOCK_COMMAS);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COMMAS);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] phase, phase_nxt;
  logic [3:0] comma_cnt, comma_cnt_nxt;
  logic [3:0] mis_cnt, mis_cnt_nxt;
  logic       match;
  logic       boundary;
  logic       emit;

  assign match    = (parallel_in == COMMA_N) || (parallel_in == COMMA_P);
  // phase is loaded with 1 on detection, so 0 marks every 10th cycle after it
  assign boundary = (state != HUNT) && (phase == 4'd0);

  always_comb begin
    state_nxt     = state;
    phase_nxt     = (phase == 4'd9) ? 4'd0 : phase + 4'd1;
    comma_cnt_nxt = comma_cnt;
    mis_cnt_nxt   = mis_cnt;
    emit          = 1'b0;
    case (state)
      HUNT: begin
        phase_nxt = 4'd0;
        if (match) begin
          phase_nxt     = 4'd1;
          comma_cnt_nxt = 4'd1;
          mis_cnt_nxt   = 4'd0;
          if (LOCK_N == 4'd1) begin
            state_nxt = LOCKED;
            emit      = 1'b1;
          end else begin
            state_nxt = CONFIRM;
          end
        end
      end
      CONFIRM: begin
        if (match) begin
          if (boundary) begin
            comma_cnt_nxt = comma_cnt + 4'd1;
            if ((comma_cnt + 4'd1) >= LOCK_N) begin
              state_nxt   = LOCKED;
              mis_cnt_nxt = 4'd0;
              emit        = 1'b1;
            end
          end else begin
            phase_nxt     = 4'd1;
            comma_cnt_nxt = 4'd1;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          emit = 1'b1;
          if (match) mis_cnt_nxt = 4'd0;
        end else if (match) begin
          if ((mis_cnt + 4'd1) >= UNLOCK_N) begin
            state_nxt     = HUNT;
            phase_nxt     = 4'd0;
            comma_cnt_nxt = 4'd0;
            mis_cnt_nxt   = 4'd0;
          end else begin
            mis_cnt_nxt = mis_cnt + 4'd1;
          end
        end
      end
      default: begin
        state_nxt     = HUNT;
        phase_nxt     = 4'd0;
        comma_cnt_nxt = 4'd0;
        mis_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      phase        <= 4'd0;
      comma_cnt    <= 4'd0;
      mis_cnt      <= 4'd0;
      symbol_out   <= 10'd0;
      symbol_valid <= 1'b0;
      comma_det    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state        <= state_nxt;
      phase        <= phase_nxt;
      comma_cnt    <= comma_cnt_nxt;
      mis_cnt      <= mis_cnt_nxt;
      symbol_valid <= emit;
      comma_det    <= emit && match;
      locked       <= (state_nxt == LOCKED);
      if (emit) symbol_out <= parallel_in;
    end
  end

endmodule
